// File: rtl/ctrl_serial_pkg.sv
// Shared types and constants for the byte-serial to Wishbone controller.
package ctrl_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_TXDATA,
    S_TXSTAT,
    S_DRAIN
  } state_t;

  localparam logic [7:0] ST_OK      = 8'h01;
  localparam logic [7:0] ST_BUSERR  = 8'h02;
  localparam logic [7:0] ST_TIMEOUT = 8'h03;

  localparam int CMD_WE     = 7;
  localparam int CMD_LEN_HI = 6;
  localparam int CMD_LEN_LO = 4;
  localparam int CMD_INC    = 3;

endpackage

// File: rtl/ctrl_serial_wb_if.sv
// Wishbone B4 classic bus bundle between the serial controller (master) and the interconnect.
interface ctrl_serial_wb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/ser_shift.sv
// Byte-wide MSB-first shift register with parallel load and a byte counter that flags the last byte.
module ser_shift #(
  parameter int NB = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_clr,
  input  logic            i_shift,
  input  logic [7:0]      i_byte,
  input  logic            i_load,
  input  logic [8*NB-1:0] i_word,
  output logic [8*NB-1:0] o_word,
  output logic            o_last
);
  localparam int W  = 8 * NB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [W-1:0]  r_word;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_word <= (r_word << 8) | W'(i_byte);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_cnt == LAST);
endmodule

// File: rtl/ctrl_serial_wb.sv
// Byte-serial command transport to Wishbone B4 classic master with bursts and status reply.
// Optional bus timeout is enabled by defining CTRL_SERIAL_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a command byte
// ADDR     | collecting address bytes, MSB first
// WDATA    | collecting one write word
// BUS      | Wishbone cycle in flight
// TXDATA   | sending a read word (or zero padding after an error)
// TXSTAT   | sending the status byte
// DRAIN    | discarding write bytes left over after an error
module ctrl_serial_wb
  import ctrl_serial_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_req_i,
  input  logic [7:0]       rx_data_i,
  output logic             tx_req_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  ctrl_serial_wb_if.master wb,
  output logic             busy_o,
  output logic             rx_drop_o
);
  localparam int AB  = (ADDR_W + 7) / 8;
  localparam int DB  = DATA_W / 8;
  localparam int AW8 = 8 * AB;

  state_t      r_state;
  logic        r_we;
  logic        r_inc;
  logic        r_err;
  logic        r_cyc;
  logic        r_stb;
  logic        r_tx_req;
  logic        r_rx_drop;
  logic [2:0]  r_left;
  logic [7:0]  r_status;

  logic [AW8-1:0]    w_adr_word;
  logic [AW8-1:0]    w_adr_ldval;
  logic [ADDR_W-1:0] w_adr_inc;
  logic              w_adr_last, w_adr_shift, w_adr_load, w_adr_clr;
  logic [DATA_W-1:0] w_dat_word, w_dat_ldval;
  logic [7:0]        w_dat_byte, w_dat_msb;
  logic              w_dat_last, w_dat_shift, w_dat_load, w_dat_clr;
  logic              w_ack, w_err, w_tmo, w_abort, w_tx_take;

  // ack and err together count as err; both are ignored unless stb is up
  assign w_ack     = r_stb && wb.wb_ack_i && !wb.wb_err_i;
  assign w_err     = r_stb && wb.wb_err_i;
  assign w_abort   = w_err || w_tmo;
  assign w_tx_take = r_tx_req && tx_ready_i;

  assign w_adr_clr   = (r_state == S_IDLE) && rx_req_i;
  assign w_adr_shift = (r_state == S_ADDR) && rx_req_i;
  assign w_adr_load  = (r_state == S_BUS) && w_ack && r_inc && (r_left != 3'd0);
  assign w_adr_inc   = w_adr_word[ADDR_W-1:0] + ADDR_W'(1);
  assign w_adr_ldval = AW8'(w_adr_inc);

  // The data shifter serves write collection, drain counting and read unload
  assign w_dat_clr   = w_adr_clr;
  assign w_dat_shift = (rx_req_i && (r_state == S_WDATA || r_state == S_DRAIN)) ||
                       ((r_state == S_TXDATA) && w_tx_take);
  assign w_dat_byte  = (r_state == S_TXDATA) ? 8'h00 : rx_data_i;
  assign w_dat_load  = ((r_state == S_BUS) && !r_we && (w_ack || w_abort)) ||
                       ((r_state == S_TXDATA) && w_tx_take && w_dat_last && r_err &&
                        (r_left != 3'd0));
  assign w_dat_ldval = w_ack ? wb.wb_dat_i : '0;
  assign w_dat_msb   = w_dat_word[DATA_W-1 -: 8];

  ser_shift #(.NB(AB)) u_adr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_clr   (w_adr_clr),
    .i_shift (w_adr_shift),
    .i_byte  (rx_data_i),
    .i_load  (w_adr_load),
    .i_word  (w_adr_ldval),
    .o_word  (w_adr_word),
    .o_last  (w_adr_last)
  );

  ser_shift #(.NB(DB)) u_dat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_clr   (w_dat_clr),
    .i_shift (w_dat_shift),
    .i_byte  (w_dat_byte),
    .i_load  (w_dat_load),
    .i_word  (w_dat_ldval),
    .o_word  (w_dat_word),
    .o_last  (w_dat_last)
  );

`ifdef CTRL_SERIAL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !r_stb) r_tmo_cnt <= '0;
    else                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = r_stb && !wb.wb_ack_i && !wb.wb_err_i && (r_tmo_cnt == TCW'(TIMEOUT - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT != 0);
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_inc     <= 1'b0;
      r_err     <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_tx_req  <= 1'b0;
      r_rx_drop <= 1'b0;
      r_left    <= 3'd0;
      r_status  <= 8'h00;
    end else begin
      r_rx_drop <= rx_req_i &&
                   (r_state == S_BUS || r_state == S_TXDATA || r_state == S_TXSTAT);
      case (r_state)
        S_IDLE: if (rx_req_i) begin
          r_we     <= rx_data_i[CMD_WE];
          r_left   <= rx_data_i[CMD_LEN_HI:CMD_LEN_LO];
          r_inc    <= rx_data_i[CMD_INC];
          r_err    <= 1'b0;
          r_status <= ST_OK;
          r_state  <= S_ADDR;
        end
        S_ADDR: if (rx_req_i && w_adr_last) begin
          if (r_we) begin
            r_state <= S_WDATA;
          end else begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= S_BUS;
          end
        end
        S_WDATA: if (rx_req_i && w_dat_last) begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_state <= S_BUS;
        end
        S_BUS: if (w_ack || w_abort) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          if (w_abort) begin
            r_err    <= 1'b1;
            r_status <= w_tmo ? ST_TIMEOUT : ST_BUSERR;
          end
          if (!r_we) begin
            r_tx_req <= 1'b1;
            r_state  <= S_TXDATA;
          end else if (r_left == 3'd0) begin
            r_tx_req <= 1'b1;
            r_state  <= S_TXSTAT;
          end else if (w_abort) begin
            r_state <= S_DRAIN;
          end else begin
            r_left  <= r_left - 3'd1;
            r_state <= S_WDATA;
          end
        end
        S_TXDATA: if (w_tx_take && w_dat_last) begin
          if (r_left != 3'd0) begin
            r_left <= r_left - 3'd1;
            // after an error the remaining words are zero padding, no bus cycles
            if (!r_err) begin
              r_tx_req <= 1'b0;
              r_cyc    <= 1'b1;
              r_stb    <= 1'b1;
              r_state  <= S_BUS;
            end
          end else begin
            r_state <= S_TXSTAT;
          end
        end
        S_TXSTAT: if (w_tx_take) begin
          r_tx_req <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_DRAIN: if (rx_req_i && w_dat_last) begin
          r_left <= r_left - 3'd1;
          if (r_left == 3'd1) begin
            r_tx_req <= 1'b1;
            r_state  <= S_TXSTAT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_req_o  = r_tx_req;
  assign tx_data_o = !r_tx_req ? 8'h00 : (r_state == S_TXSTAT) ? r_status : w_dat_msb;
  assign busy_o    = (r_state != S_IDLE);
  assign rx_drop_o = r_rx_drop;

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_stb;
  assign wb.wb_we_o  = r_cyc && r_we;
  assign wb.wb_adr_o = w_adr_word[ADDR_W-1:0];
  assign wb.wb_dat_o = w_dat_word;
  assign wb.wb_sel_o = {(DATA_W/8){r_cyc}};
endmodule

// File: tb/tb_ctrl_serial_wb.sv
// Directed-vector bench for ctrl_serial_wb; the timeout case runs when CTRL_SERIAL_TIMEOUT_EN is defined.
module tb_ctrl_serial_wb;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk_i      = 1'b0;
  logic        rst_i      = 1'b1;
  logic        rx_req_i   = 1'b0;
  logic [7:0]  rx_data_i  = 8'h00;
  logic        tx_ready_i = 1'b0;
  logic        tx_req_o;
  logic [7:0]  tx_data_o;
  logic        busy_o;
  logic        rx_drop_o;

  int n_vec = 0;
  int n_bad = 0;
  int n_cyc = 0;
  logic stb_q = 1'b0;

  ctrl_serial_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  ctrl_serial_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_req_i   (rx_req_i),
    .rx_data_i  (rx_data_i),
    .tx_req_o   (tx_req_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .wb         (wb),
    .busy_o     (busy_o),
    .rx_drop_o  (rx_drop_o)
  );

  always #5 clk_i = ~clk_i;

  // count bus cycles by stb rising edges
  always @(posedge clk_i) begin
    if (wb.wb_stb_o && !stb_q) n_cyc++;
    stb_q = wb.wb_stb_o;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_req_i  = 1'b1;
    rx_data_i = b;
    tick();
    rx_req_i  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (!wb.wb_stb_o && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, "_stb"}, 32'(wb.wb_stb_o), 32'd1);
  endtask

  task automatic bus_done(input string tag, input logic [31:0] d, input logic ack, input logic err);
    wb.wb_dat_i = d;
    wb.wb_ack_i = ack;
    wb.wb_err_i = err;
    tick();
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    check_val({tag, "_cyc_drop"}, 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
    int n = 0;
    logic [7:0] held;
    logic ok;
    while (!tx_req_o && n < 50) begin
      tick();
      n++;
    end
    check_val({tag, "_req"}, 32'(tx_req_o), 32'd1);
    held = tx_data_o;
    ok   = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!tx_req_o || tx_data_o !== held) ok = 1'b0;
    end
    if (stall > 0) check_val({tag, "_hold"}, 32'(ok), 32'd1);
    check_val(tag, 32'(tx_data_o), 32'(exp));
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
  endtask

  task automatic recv_word(input string tag, input logic [31:0] w, input int stall);
    for (int i = 3; i >= 0; i--) recv_byte(tag, w[8*i +: 8], stall);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_idle"}, 32'({busy_o, tx_req_o, wb.wb_cyc_o}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    wb.wb_dat_i = '0;
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    tick();
    tick();
    check_val("rst_ctrl", 32'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, tx_req_o, busy_o, rx_drop_o}), 32'd0);
    check_val("rst_bus", 32'(wb.wb_adr_o) | wb.wb_dat_o | 32'(wb.wb_sel_o) | 32'(tx_data_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // single read
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    check_val("rd_stb", 32'(wb.wb_stb_o), 32'd1);
    check_val("rd_adr", 32'(wb.wb_adr_o), 32'h1234);
    check_val("rd_we", 32'(wb.wb_we_o), 32'd0);
    check_val("rd_sel", 32'(wb.wb_sel_o), 32'hF);
    bus_done("rd", 32'hDEADBEEF, 1'b1, 1'b0);
    check_val("rd_txlat", 32'(tx_req_o), 32'd1);
    recv_word("rd_data", 32'hDEADBEEF, 0);
    recv_byte("rd_stat", 8'h01, 0);
    check_idle("rd");

    // write burst of 2 with increment
    send_byte(8'h98); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_val("wr_nostb", 32'(wb.wb_stb_o), 32'd0);
    send_byte(8'h44);
    check_val("wr1_stb", 32'(wb.wb_stb_o), 32'd1);
    check_val("wr1_adr", 32'(wb.wb_adr_o), 32'h0010);
    check_val("wr1_we", 32'(wb.wb_we_o), 32'd1);
    check_val("wr1_dat", wb.wb_dat_o, 32'h11223344);
    check_val("wr1_sel", 32'(wb.wb_sel_o), 32'hF);
    bus_done("wr1", 32'h0, 1'b1, 1'b0);
    check_val("wr1_notx", 32'({busy_o, tx_req_o}), 32'b10);
    send_word(32'h55667788);
    check_val("wr2_stb", 32'(wb.wb_stb_o), 32'd1);
    check_val("wr2_adr", 32'(wb.wb_adr_o), 32'h0011);
    check_val("wr2_dat", wb.wb_dat_o, 32'h55667788);
    bus_done("wr2", 32'h0, 1'b1, 1'b0);
    recv_byte("wr_stat", 8'h01, 0);
    check_idle("wr");

    // read burst of 3, fixed address, error on word 2
    c0 = n_cyc;
    send_byte(8'h20); send_byte(8'hAB); send_byte(8'hCD);
    check_val("rb1_adr", 32'(wb.wb_adr_o), 32'hABCD);
    bus_done("rb1", 32'h01020304, 1'b1, 1'b0);
    recv_word("rb1_data", 32'h01020304, 0);
    wait_stb("rb2");
    check_val("rb2_adr", 32'(wb.wb_adr_o), 32'hABCD);
    bus_done("rb2", 32'h0, 1'b0, 1'b1);
    recv_word("rb_pad2", 32'h0, 0);
    recv_word("rb_pad3", 32'h0, 0);
    recv_byte("rb_stat", 8'h02, 0);
    tick();
    check_val("rb_ncyc", 32'(n_cyc - c0), 32'd2);
    check_idle("rb");

    // write burst of 2 with error on word 1: second word drained
    c0 = n_cyc;
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h20);
    send_word(32'hDEADBEEF);
    check_val("we_adr", 32'(wb.wb_adr_o), 32'h0020);
    bus_done("we", 32'h0, 1'b0, 1'b1);
    check_val("we_drain", 32'({busy_o, tx_req_o}), 32'b10);
    send_word(32'hCAFEBABE);
    check_val("we_txlat", 32'(tx_req_o), 32'd1);
    recv_byte("we_stat", 8'h02, 0);
    tick();
    check_val("we_ncyc", 32'(n_cyc - c0), 32'd1);

    // ack and err in the same cycle count as error
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
    bus_done("ae", 32'h12345678, 1'b1, 1'b1);
    recv_word("ae_pad", 32'h0, 0);
    recv_byte("ae_stat", 8'h02, 0);

    // tx backpressure
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    bus_done("bp", 32'hCAFEF00D, 1'b1, 1'b0);
    recv_word("bp_data", 32'hCAFEF00D, 5);
    recv_byte("bp_stat", 8'h01, 5);
    check_idle("bp");

    // rx byte during BUS is dropped
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h42);
    send_byte(8'h5A);
    check_val("drop_pulse", 32'(rx_drop_o), 32'd1);
    check_val("drop_stb", 32'(wb.wb_stb_o), 32'd1);
    check_val("drop_adr", 32'(wb.wb_adr_o), 32'h0042);
    tick();
    check_val("drop_once", 32'(rx_drop_o), 32'd0);
    bus_done("drop", 32'h89ABCDEF, 1'b1, 1'b0);
    recv_word("drop_data", 32'h89ABCDEF, 0);
    recv_byte("drop_stat", 8'h01, 0);

    // reset during BUS, then reset mid-WDATA, then a clean frame
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h40);
    send_word(32'h01020304);
    check_val("rstb_stb", 32'(wb.wb_stb_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("rstb");
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h01); send_byte(8'h02);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("rstw");
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h77);
    check_val("post_stb", 32'(wb.wb_stb_o), 32'd1);
    check_val("post_adr", 32'(wb.wb_adr_o), 32'h0077);
    check_val("post_we", 32'(wb.wb_we_o), 32'd0);
    bus_done("post", 32'h0BADF00D, 1'b1, 1'b0);
    recv_word("post_data", 32'h0BADF00D, 0);
    recv_byte("post_stat", 8'h01, 0);
    check_idle("post");

`ifdef CTRL_SERIAL_TIMEOUT_EN
    // no ack: abort after TIMEOUT cycles, late ack ignored
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h99);
    n = 0;
    while (wb.wb_stb_o && n < 100) begin
      tick();
      n++;
    end
    check_val("tmo_len", 32'(n), 32'd16);
    check_val("tmo_tx", 32'(tx_req_o), 32'd1);
    wb.wb_dat_i = 32'hFFFFFFFF;
    wb.wb_ack_i = 1'b1;
    tick();
    wb.wb_ack_i = 1'b0;
    check_val("tmo_late", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 32'd0);
    recv_word("tmo_pad", 32'h0, 0);
    recv_byte("tmo_stat", 8'h03, 0);
    check_idle("tmo");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
